// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with write-back bypass, load-use stall, flush and bubble counter
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] bus1,
  input  logic [DATA_W-1:0] bus2,
  input  logic [IMM_W-1:0]  imm,
  input  logic [9:0]        ctrl_in,
  input  logic              wb_wena,
  input  logic [4:0]        wb_dir,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [9:0]        ex_ctrl,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic [DATA_W-1:0] opa, opb;
  logic haz, bubble;
  // same-cycle write-back wins over the stale register bank read; r0 is never bypassed
  always_comb begin
    opa = (wb_wena && wb_dir != 5'd0 && wb_dir == rs) ? wb_data : bus1;
    opb = (wb_wena && wb_dir != 5'd0 && wb_dir == rt) ? wb_data : bus2;
    haz = in_valid && ex_valid && ex_ctrl[8] && ex_rt != 5'd0 && (ex_rt == rs || ex_rt == rt);
    stall = haz && !flush;
    bubble = flush || haz;
  end
  // capture the decoded instruction or insert a bubble; only load-use bubbles are counted
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      bubble_cnt <= '0;
    end else begin
      ex_valid <= bubble ? 1'b0 : in_valid;
      ex_ctrl  <= (bubble || !in_valid) ? '0 : ctrl_in;
      ex_a     <= bubble ? '0 : opa;
      ex_b     <= bubble ? '0 : opb;
      ex_imm   <= bubble ? '0 : {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      ex_rs    <= bubble ? '0 : rs;
      ex_rt    <= bubble ? '0 : rt;
      ex_rd    <= bubble ? '0 : rd;
      if (stall && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;
  logic clk = 0, rst = 0;
  logic in_valid = 0, wb_wena = 0, flush = 0;
  logic [4:0] rs = 0, rt = 0, rd = 0, wb_dir = 0;
  logic [31:0] bus1 = 0, bus2 = 0, wb_data = 0;
  logic [15:0] imm = 0;
  logic [9:0] ctrl_in = 0;
  logic stall, ex_valid;
  logic [9:0] ex_ctrl;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [1:0] bubble_cnt;
  int tests = 0, fails = 0;
  int m_valid, m_ctrl, m_rs, m_rt, m_rd, m_cnt;
  logic [31:0] m_a, m_b, m_imm;

  id_ex_stage #(.DATA_W(32), .IMM_W(16), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rs(rs), .rt(rt), .rd(rd),
    .bus1(bus1), .bus2(bus2), .imm(imm), .ctrl_in(ctrl_in),
    .wb_wena(wb_wena), .wb_dir(wb_dir), .wb_data(wb_data), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input bit with_cnt);
    m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    if (with_cnt) m_cnt = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".ctrl"}, 32'(ex_ctrl), 32'(m_ctrl));
    chk({tag, ".a"}, ex_a, m_a);
    chk({tag, ".b"}, ex_b, m_b);
    chk({tag, ".imm"}, ex_imm, m_imm);
    chk({tag, ".rs"}, 32'(ex_rs), 32'(m_rs));
    chk({tag, ".rt"}, 32'(ex_rt), 32'(m_rt));
    chk({tag, ".rd"}, 32'(ex_rd), 32'(m_rd));
    chk({tag, ".cnt"}, 32'(bubble_cnt), 32'(m_cnt));
  endtask

  // drive one ID-stage cycle, check stall before the edge and all registers after it
  task automatic step(input string tag, input bit iv, input int a, input int b, input int d,
                      input logic [31:0] b1, input logic [31:0] b2, input logic [15:0] im,
                      input logic [9:0] ctl, input bit we, input int wd, input logic [31:0] wdat,
                      input bit fl);
    bit haz;
    in_valid = iv; rs = 5'(a); rt = 5'(b); rd = 5'(d); bus1 = b1; bus2 = b2; imm = im;
    ctrl_in = ctl; wb_wena = we; wb_dir = 5'(wd); wb_data = wdat; flush = fl;
    haz = iv && m_valid != 0 && m_ctrl[8] && m_rt != 0 && (m_rt == a || m_rt == b);
    #1 chk({tag, ".stall"}, 32'(stall), 32'(haz && !fl));
    if (fl) model_clear(0);
    else if (haz) begin
      model_clear(0);
      if (m_cnt < 3) m_cnt++;
    end else begin
      m_valid = iv;
      m_ctrl = iv ? ctl : 0;
      m_a = (we && wd != 0 && wd == a) ? wdat : b1;
      m_b = (we && wd != 0 && wd == b) ? wdat : b2;
      m_imm = im[15] ? 32'(im) - 32'h10000 : 32'(im);
      m_rs = a; m_rt = b; m_rd = d;
    end
    @(posedge clk);
    #1 chk_all(tag);
  endtask

  initial begin
    model_clear(1);
    repeat (2) @(posedge clk);
    #1 chk_all("reset");
    chk("reset.stall", 32'(stall), 0);
    rst = 1;
    step("capture", 1, 1, 2, 4, 3, 7, 16'hFFFE, 10'h201, 0, 0, 0, 0);
    step("bypass_a", 1, 1, 2, 0, 0, 7, 16'h0010, 10'h221, 1, 1, 32'hA5, 0);
    step("bypass_ab", 1, 6, 6, 0, 1, 2, 16'h0001, 10'h221, 1, 6, 32'h77, 0);
    step("no_byp_r0", 1, 0, 2, 0, 32'h11, 7, 16'h7FFF, 10'h201, 1, 0, 5, 0);
    step("lw", 1, 1, 3, 0, 9, 9, 0, 10'h300, 0, 0, 0, 0);
    step("use_stall", 1, 3, 4, 5, 8, 8, 0, 10'h201, 0, 0, 0, 0);
    step("use_enter", 1, 3, 4, 5, 8, 8, 0, 10'h201, 0, 0, 0, 0);
    step("lw2", 1, 1, 5, 0, 9, 9, 0, 10'h300, 0, 0, 0, 0);
    step("flush_haz", 1, 5, 0, 0, 8, 8, 0, 10'h201, 0, 0, 0, 1);
    step("lw_r0", 1, 1, 0, 0, 9, 9, 0, 10'h300, 0, 0, 0, 0);
    step("use_r0", 1, 0, 0, 0, 8, 8, 0, 10'h201, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("sat_lw", 1, 1, 7, 0, 9, 9, 0, 10'h300, 0, 0, 0, 0);
      step("sat_use", 1, 2, 7, 0, 8, 8, 0, 10'h201, 0, 0, 0, 0);
    end
    chk("saturated", 32'(bubble_cnt), 3);
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 31), $urandom, $urandom, 16'($urandom), 10'($urandom),
           1'($urandom), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 7) == 0));
    step("rst_lw", 1, 1, 6, 0, 9, 9, 0, 10'h300, 0, 0, 0, 0);
    in_valid = 1; rs = 6; rt = 1; flush = 0;
    #1 chk("pre_rst.stall", 32'(stall), 1);
    #2 rst = 0;
    #1 model_clear(1);
    chk_all("async_rst");
    chk("async_rst.stall", 32'(stall), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
